// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared constants and helpers for the SDF FFT stage controllers.
//   ST_*   : per-sample butterfly/multiplier control code presented on o_state
//   FSM_*  : internal sequencing state of the stage controller
//   clog2  : ceiling log2 for parameter-derived widths
//   tw_cos : round(cos(2*pi*k/L) * 2^FRAC), used only to build constant tables
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_BFLY  = 2'd1;
    localparam logic [1:0] ST_TWID  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [1:0] FSM_IDLE  = 2'd0;
    localparam logic [1:0] FSM_FILL  = 2'd1;
    localparam logic [1:0] FSM_RUN   = 2'd2;
    localparam logic [1:0] FSM_DRAIN = 2'd3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Round half away from zero so that symmetric entries negate exactly.
    function automatic int tw_cos(input int k, input int l, input int frac);
        real v;
        v = $cos(2.0 * 3.14159265358979323846 * real'(k) / real'(l)) * real'(1 << frac);
        if (v >= 0.0) return $rtoi(v + 0.5);
        else          return -$rtoi(-v + 0.5);
    endfunction

endpackage

// File: rtl/fft_twiddle_qrom.sv
// -----------------------------------------------------------------------------
// fft_twiddle_qrom
// Combinational quarter-wave twiddle lookup for the forward direction:
//   W(k) = cos(2*pi*k/L) - j*sin(2*pi*k/L), k = 0..L/2-1, scaled by 2^FRAC.
// Only the L/4+1 cosine values are stored; the rest come from symmetry.
// Ports:
//   i_k    in  log2(L)-1  twiddle index
//   o_w_r  out W          real part   ( cos)
//   o_w_i  out W          imag part   (-sin)
// -----------------------------------------------------------------------------
module fft_twiddle_qrom
    import fft_pkg::*;
#(
    parameter int STAGE_L = 8,
    parameter int W       = 24,
    parameter int FRAC    = 8
) (
    input  logic        [clog2(STAGE_L)-2:0] i_k,
    output logic signed [W-1:0]              o_w_r,
    output logic signed [W-1:0]              o_w_i
);

    localparam int KW = clog2(STAGE_L) - 1;
    localparam int H  = STAGE_L / 2;
    localparam int Q  = STAGE_L / 4;

    // Table is padded to H entries so any KW-bit index stays in range;
    // entries above Q are never selected.
    logic signed [W-1:0] w_tbl [H];

    for (genvar g = 0; g < H; g++) begin : g_tbl
        if (g <= Q) begin : g_val
            assign w_tbl[g] = W'(tw_cos(g, STAGE_L, FRAC));
        end else begin : g_pad
            assign w_tbl[g] = '0;
        end
    end

    logic          w_upper;
    logic [KW-1:0] w_cos_idx;
    logic [KW-1:0] w_sin_idx;

    always_comb begin
        w_upper = (i_k > KW'(Q));
        // H-k: H is 2^KW, so it vanishes modulo the index width.
        w_cos_idx = w_upper ? (KW'(0) - i_k) : i_k;
        w_sin_idx = w_upper ? (i_k - KW'(Q)) : (KW'(Q) - i_k);
        o_w_r     = w_upper ? -w_tbl[w_cos_idx] : w_tbl[w_cos_idx];
        o_w_i     = -w_tbl[w_sin_idx];
    end

endmodule

// File: rtl/fft_sdf_twiddle_gen.sv
// -----------------------------------------------------------------------------
// fft_sdf_twiddle_gen
// Twiddle and control generator for one radix-2 SDF FFT stage of span L.
// Handshake: i_in_valid is a valid-only strobe (no backpressure); a sample is
// accepted in any cycle i_in_valid=1 outside the drain phase. Results for a
// sample accepted in cycle t are presented in cycle t+1 with o_out_valid=1.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_in_valid        sample accepted this cycle
//   i_frame_start     accepted sample is index 0 of a new frame
//   i_inverse         IFFT mode, latched at frame start
//   o_out_valid       outputs below are valid this cycle
//   o_state           0 FILL, 1 BFLY, 2 TWID, 3 DRAIN
//   o_w_r, o_w_i      twiddle, Q(W-FRAC).FRAC two's complement
//   o_k_idx           twiddle index presented
//   o_err             sticky: in_valid arrived while draining
//   o_dbg_fsm         internal FSM (IDLE/FILL/RUN/DRAIN)
// -----------------------------------------------------------------------------
module fft_sdf_twiddle_gen
    import fft_pkg::*;
#(
    parameter int FFT_N   = 256,
    parameter int STAGE_L = 8,
    parameter int W       = 24,
    parameter int FRAC    = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_in_valid,
    input  logic                             i_frame_start,
    input  logic                             i_inverse,
    output logic                             o_out_valid,
    output logic        [1:0]                o_state,
    output logic signed [W-1:0]              o_w_r,
    output logic signed [W-1:0]              o_w_i,
    output logic        [clog2(STAGE_L)-2:0] o_k_idx,
    output logic                             o_err,
    output logic        [1:0]                o_dbg_fsm
);

    localparam int KW = clog2(STAGE_L) - 1;
    localparam int NW = clog2(FFT_N);
    localparam int H  = STAGE_L / 2;

    logic        [1:0]    r_fsm;
    logic        [NW-1:0] r_smp_cnt;   // index the next accepted sample takes
    logic        [KW-1:0] r_drn_cnt;
    logic                 r_inv;
    logic                 r_out_valid;
    logic        [1:0]    r_state;
    logic signed [W-1:0]  r_w_r;
    logic signed [W-1:0]  r_w_i;
    logic        [KW-1:0] r_k_idx;
    logic                 r_err;

    logic                 w_in_drain;
    logic                 w_new_frame;
    logic                 w_last_smp;
    logic                 w_inv_eff;
    logic        [NW-1:0] w_idx;
    logic        [1:0]    w_st;
    logic        [KW-1:0] w_k;
    logic signed [W-1:0]  w_fw_r;
    logic signed [W-1:0]  w_fw_i;

    always_comb begin
        w_in_drain  = (r_fsm == FSM_DRAIN);
        w_new_frame = (r_fsm == FSM_IDLE) || i_frame_start;
        w_idx       = w_new_frame ? '0 : r_smp_cnt;
        w_last_smp  = (w_idx == NW'(FFT_N - 1));
        w_st        = ST_FILL;
        w_k         = '0;
        w_inv_eff   = r_inv;
        if (w_in_drain) begin
            w_st = ST_DRAIN;
            w_k  = r_drn_cnt;
        end else begin
            if (w_new_frame) w_inv_eff = i_inverse;
            // Butterfly/rotate halves run H samples behind the input position:
            // (s-H) mod L < H is BFLY. Subtracting H=2^KW flips bit KW, so the
            // rotate half is where bit KW of s is clear, with k = s mod H.
            if (w_idx < NW'(H)) begin
                w_st = ST_FILL;
            end else if (w_idx[KW]) begin
                w_st = ST_BFLY;
            end else begin
                w_st = ST_TWID;
                w_k  = w_idx[KW-1:0];
            end
        end
    end

    fft_twiddle_qrom #(
        .STAGE_L (STAGE_L),
        .W       (W),
        .FRAC    (FRAC)
    ) u_qrom (
        .i_k   (w_k),
        .o_w_r (w_fw_r),
        .o_w_i (w_fw_i)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= FSM_IDLE;
            r_smp_cnt   <= '0;
            r_drn_cnt   <= '0;
            r_inv       <= 1'b0;
            r_out_valid <= 1'b0;
            r_state     <= ST_FILL;
            r_w_r       <= W'(1 << FRAC);
            r_w_i       <= '0;
            r_k_idx     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_in_drain || i_in_valid) begin
                r_out_valid <= 1'b1;
                r_state     <= w_st;
                r_k_idx     <= w_k;
                r_w_r       <= w_fw_r;
                r_w_i       <= w_inv_eff ? -w_fw_i : w_fw_i;
            end
            if (w_in_drain) begin
                // Samples arriving while draining are dropped and flagged.
                if (i_in_valid) r_err <= 1'b1;
                if (r_drn_cnt == KW'(H - 1)) begin
                    r_fsm     <= FSM_IDLE;
                    r_drn_cnt <= '0;
                end else begin
                    r_drn_cnt <= r_drn_cnt + KW'(1);
                end
            end else if (i_in_valid) begin
                if (w_new_frame) r_inv <= i_inverse;
                if (w_last_smp) begin
                    r_fsm     <= FSM_DRAIN;
                    r_smp_cnt <= '0;
                    r_drn_cnt <= '0;
                end else begin
                    r_smp_cnt <= w_idx + NW'(1);
                    r_fsm     <= (w_idx < NW'(H - 1)) ? FSM_FILL : FSM_RUN;
                end
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_state     = r_state;
    assign o_w_r       = r_w_r;
    assign o_w_i       = r_w_i;
    assign o_k_idx     = r_k_idx;
    assign o_err       = r_err;
    assign o_dbg_fsm   = r_fsm;

endmodule

// File: tb/tb_fft_sdf_twiddle_gen.sv
// -----------------------------------------------------------------------------
// tb_fft_sdf_twiddle_gen
// Directed bench. Instance A: FFT_N=16, L=8 (H=4), W=24, FRAC=8.
// Instance B: FFT_N=32, L=16 (H=8), W=16, FRAC=8.
// Twiddle constants are hand-computed: cos(pi/4)*256 = 181.02 -> 181.
// -----------------------------------------------------------------------------
module tb_fft_sdf_twiddle_gen;

    localparam int A_W = 24;
    localparam int B_W = 16;

    // clock/reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a_n;
    logic rst_b_n;

    logic                  a_valid, a_fs, a_inv;
    logic                  a_ov, a_err;
    logic [1:0]            a_st, a_fsm;
    logic signed [A_W-1:0] a_wr, a_wi;
    logic [1:0]            a_k;

    logic                  b_valid, b_fs, b_inv;
    logic                  b_ov, b_err;
    logic [1:0]            b_st, b_fsm;
    logic signed [B_W-1:0] b_wr, b_wi;
    logic [2:0]            b_k;

    fft_sdf_twiddle_gen #(.FFT_N(16), .STAGE_L(8), .W(A_W), .FRAC(8)) dut_a (
        .clk           (clk),
        .rst_n         (rst_a_n),
        .i_in_valid    (a_valid),
        .i_frame_start (a_fs),
        .i_inverse     (a_inv),
        .o_out_valid   (a_ov),
        .o_state       (a_st),
        .o_w_r         (a_wr),
        .o_w_i         (a_wi),
        .o_k_idx       (a_k),
        .o_err         (a_err),
        .o_dbg_fsm     (a_fsm)
    );

    fft_sdf_twiddle_gen #(.FFT_N(32), .STAGE_L(16), .W(B_W), .FRAC(8)) dut_b (
        .clk           (clk),
        .rst_n         (rst_b_n),
        .i_in_valid    (b_valid),
        .i_frame_start (b_fs),
        .i_inverse     (b_inv),
        .o_out_valid   (b_ov),
        .o_state       (b_st),
        .o_w_r         (b_wr),
        .o_w_i         (b_wi),
        .o_k_idx       (b_k),
        .o_err         (b_err),
        .o_dbg_fsm     (b_fsm)
    );

    // scoreboard
    int   n_pass  = 0;
    int   n_total = 0;
    logic exp_err = 1'b0;
    // L=8 forward twiddles, k = 0..3
    int   tw_r[4] = '{256, 181, 0, -181};
    int   tw_i[4] = '{0, -181, -256, -181};

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_a(input string tag, input logic ev, input int es, input int ek,
                         input int er, input int ei);
        chk({tag, ".valid"}, 32'(a_ov), 32'(ev));
        chk({tag, ".state"}, 32'(a_st), es);
        chk({tag, ".k"},     32'(a_k),  ek);
        chk({tag, ".w_r"},   a_wr,      er);
        chk({tag, ".w_i"},   a_wi,      ei);
        chk({tag, ".err"},   32'(a_err), 32'(exp_err));
    endtask

    task automatic chk_b(input string tag, input logic ev, input int es, input int ek,
                         input int er, input int ei);
        chk({tag, ".valid"}, 32'(b_ov), 32'(ev));
        chk({tag, ".state"}, 32'(b_st), es);
        chk({tag, ".k"},     32'(b_k),  ek);
        chk({tag, ".w_r"},   b_wr,      er);
        chk({tag, ".w_i"},   b_wi,      ei);
        chk({tag, ".err"},   32'(b_err), 0);
    endtask

    // driver tasks: inputs change 1 time unit after the edge, checks follow
    task automatic send_a(input int s, input logic fs, input logic inv, input logic inv_frame);
        int st, k, wr, wi;
        a_valid = 1'b1; a_fs = fs; a_inv = inv;
        @(posedge clk); #1;
        a_valid = 1'b0; a_fs = 1'b0; a_inv = 1'b0;
        st = 0; k = 0; wr = 256; wi = 0;
        if (s >= 4) begin
            if ((s - 4) % 8 < 4) begin
                st = 1;
            end else begin
                st = 2;
                k  = (s - 4) % 8 - 4;
                wr = tw_r[k];
                wi = inv_frame ? -tw_i[k] : tw_i[k];
            end
        end
        chk_a($sformatf("a.s%0d", s), 1'b1, st, k, wr, wi);
    endtask

    task automatic drain_a(input int d, input logic inv_frame, input logic v);
        a_valid = v;
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk_a($sformatf("a.drain%0d", d), 1'b1, 3, d, tw_r[d],
              inv_frame ? -tw_i[d] : tw_i[d]);
    endtask

    task automatic idle_a(input string tag, input int st, input int k, input int wr, input int wi);
        a_valid = 1'b0;
        @(posedge clk); #1;
        chk_a(tag, 1'b0, st, k, wr, wi);
    endtask

    task automatic send_b(input int s, input logic fs);
        int st, k;
        b_valid = 1'b1; b_fs = fs; b_inv = 1'b0;
        @(posedge clk); #1;
        b_valid = 1'b0; b_fs = 1'b0;
        st = 0; k = 0;
        if (s >= 8) begin
            if ((s - 8) % 16 < 8) st = 1;
            else begin st = 2; k = (s - 8) % 16 - 8; end
        end
        chk($sformatf("b.s%0d.state", s), 32'(b_st), st);
        chk($sformatf("b.s%0d.k", s),     32'(b_k),  k);
    endtask

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        a_valid = 1'b0; a_fs = 1'b0; a_inv = 1'b0;
        b_valid = 1'b0; b_fs = 1'b0; b_inv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // reset values
        chk_a("a.rst", 1'b0, 0, 0, 256, 0);
        chk("a.rst.fsm", 32'(a_fsm), 0);
        chk_b("b.rst", 1'b0, 0, 0, 256, 0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;

        // forward frame: fill, butterfly, rotate, a mid-frame hold, then drain
        for (int s = 0; s < 16; s++) begin
            send_a(s, s == 0, 1'b0, 1'b0);
            if (s == 5) idle_a("a.hold", 1, 0, 256, 0);
        end
        chk("a.fsm.drain", 32'(a_fsm), 3);
        for (int d = 0; d < 4; d++) drain_a(d, 1'b0, 1'b0);
        idle_a("a.after_drain", 3, 3, -181, -181);

        // inverse frame: inverse only asserted with frame_start
        for (int s = 0; s < 16; s++) send_a(s, s == 0, s == 0, 1'b1);
        for (int d = 0; d < 4; d++) drain_a(d, 1'b1, 1'b0);
        idle_a("a.after_inv", 3, 3, -181, 181);

        // forward frame with inverse toggling mid-frame (ignored) and a
        // sample during drain cycle 1 (flagged, drain length unchanged)
        for (int s = 0; s < 16; s++) send_a(s, s == 0, s != 0, 1'b0);
        drain_a(0, 1'b0, 1'b0);
        exp_err = 1'b1;
        drain_a(1, 1'b0, 1'b1);
        drain_a(2, 1'b0, 1'b0);
        drain_a(3, 1'b0, 1'b0);
        // frame_start while the last drain result is on the outputs
        send_a(0, 1'b1, 1'b0, 1'b0);
        for (int s = 1; s <= 8; s++) send_a(s, 1'b0, 1'b0, 1'b0);
        // frame_start at sample 9 aborts and restarts at index 0
        send_a(0, 1'b1, 1'b0, 1'b0);
        for (int s = 1; s <= 4; s++) send_a(s, 1'b0, 1'b0, 1'b0);

        // L=16, W=16 instance
        for (int s = 0; s <= 22; s++) begin
            send_b(s, s == 0);
            if (s == 18) chk_b("b.k2", 1'b1, 2, 2, 181, -181);
            if (s == 20) chk_b("b.k4", 1'b1, 2, 4, 0, -256);
            if (s == 22) chk_b("b.k6", 1'b1, 2, 6, -181, -181);
        end
        // asynchronous reset in the middle of the rotate phase
        b_valid = 1'b1;
        #2;
        rst_b_n = 1'b0;
        #1;
        chk_b("b.async_rst", 1'b0, 0, 0, 256, 0);
        b_valid = 1'b0;
        @(posedge clk); #1;
        rst_b_n = 1'b1;
        send_b(0, 1'b0);
        chk_b("b.restart", 1'b1, 0, 0, 256, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
